pipe_sub: RTL and testbench

PIPE_SUB -- requirements
Module: pipe_sub

---
 rtl/pipe_sub.sv | 111 +++++++++++
 tb/tb_pipe_sub.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sub.sv
// pipe_sub: valid/ready pipelined subtractor, one WIDTH/STAGES-bit chunk per stage.
// Define PIPE_SUB_SATURATE_EN to clamp diff to the signed limits on overflow.
module pipe_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);
    localparam int C = WIDTH / STAGES;

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_br;
    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];
    logic [WIDTH-1:0]  r_d [STAGES];
    logic              r_as [STAGES];
    logic              r_bs [STAGES];
    logic              r_ovf;

    logic [STAGES-1:0] w_ld;
    logic [STAGES-1:0] w_src_v;
    logic [STAGES-1:0] w_src_br;
    logic [WIDTH-1:0]  w_src_a [STAGES];
    logic [WIDTH-1:0]  w_src_b [STAGES];
    logic [WIDTH-1:0]  w_src_d [STAGES];
    logic [WIDTH-1:0]  w_nd [STAGES];
    logic              w_src_as [STAGES];
    logic              w_src_bs [STAGES];
    logic [C:0]        w_sub [STAGES];
    logic              w_ovf;

    // Operands are shifted right as they travel, so each stage always works on the low chunk.
    always_comb begin
        w_src_v[0]  = in_valid;
        w_src_a[0]  = a;
        w_src_b[0]  = b;
        w_src_as[0] = a[WIDTH-1];
        w_src_bs[0] = b[WIDTH-1];
        w_src_d[0]  = '0;
        w_src_br[0] = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            w_src_v[k]  = r_valid[k-1];
            w_src_a[k]  = r_a[k-1];
            w_src_b[k]  = r_b[k-1];
            w_src_as[k] = r_as[k-1];
            w_src_bs[k] = r_bs[k-1];
            w_src_d[k]  = r_d[k-1];
            w_src_br[k] = r_br[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_sub[k] = {1'b0, w_src_a[k][C-1:0]} - {1'b0, w_src_b[k][C-1:0]} - {{C{1'b0}}, w_src_br[k]};
            w_nd[k]  = w_src_d[k];
            w_nd[k][k*C +: C] = w_sub[k][C-1:0];
        end
        w_ovf = (w_src_as[STAGES-1] != w_src_bs[STAGES-1]) && (w_nd[STAGES-1][WIDTH-1] != w_src_as[STAGES-1]);
`ifdef PIPE_SUB_SATURATE_EN
        if (w_ovf)
            w_nd[STAGES-1] = {w_src_as[STAGES-1], {(WIDTH-1){!w_src_as[STAGES-1]}}};
`endif
        w_ld[STAGES-1] = !r_valid[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--)
            w_ld[k] = !r_valid[k] || w_ld[k+1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_br    <= '0;
            r_ovf   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]  <= '0;
                r_b[k]  <= '0;
                r_d[k]  <= '0;
                r_as[k] <= 1'b0;
                r_bs[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ld[k])
                    r_valid[k] <= w_src_v[k];
                if (w_ld[k] && w_src_v[k]) begin
                    r_a[k]  <= w_src_a[k] >> C;
                    r_b[k]  <= w_src_b[k] >> C;
                    r_as[k] <= w_src_as[k];
                    r_bs[k] <= w_src_bs[k];
                    r_d[k]  <= w_nd[k];
                    r_br[k] <= w_sub[k][C];
                end
            end
            if (w_ld[STAGES-1] && w_src_v[STAGES-1])
                r_ovf <= w_ovf;
        end
    end

    assign in_ready  = w_ld[0];
    assign out_valid = r_valid[STAGES-1];
    assign diff      = r_d[STAGES-1];
    assign borrow    = r_br[STAGES-1];
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_sub.sv
// tb_pipe_sub: directed corner cases plus randomized traffic against an arithmetic scoreboard.
module tb_pipe_sub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;

    int          total = 0;
    int          bad = 0;
    logic [17:0] q[$];
    logic        held = 1'b0;
    logic [17:0] held_v = '0;
    logic [15:0] ta [10];
    logic [15:0] tb [10];

`ifdef PIPE_SUB_SATURATE_EN
    localparam logic [15:0] SAT_D = 16'h8000;
`else
    localparam logic [15:0] SAT_D = 16'h7FFF;
`endif

    always #5 clk = ~clk;

    pipe_sub #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .ovf(ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Result packed as {ovf, borrow, diff} from plain signed/unsigned arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y);
        int          sd;
        logic        o;
        logic [15:0] d;
        sd = int'($signed(x)) - int'($signed(y));
        o  = (sd > 32767) || (sd < -32768);
        d  = x - y;
`ifdef PIPE_SUB_SATURATE_EN
        if (o) d = (sd > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {o, x < y, d};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (in_valid && in_ready) q.push_back(model(a, b));
            if (held) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {ovf, borrow, diff}, held_v);
            end
            if (out_valid && out_ready) begin
                check("q_empty", q.size() == 0, 0);
                if (q.size() > 0) check("data", {ovf, borrow, diff}, q.pop_front());
            end
            held   = out_valid && !out_ready;
            held_v = {ovf, borrow, diff};
        end
    end

    task automatic run_one(input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] ed, input logic eb, input logic eo);
        int n;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!out_valid && n <= 20) begin
            n++;
            @(negedge clk);
        end
        check("latency", n, 4);
        check("diff", diff, ed);
        check("borrow", borrow, eb);
        check("ovf", ovf, eo);
    endtask

    initial begin
        int idx, sent, cyc, cnt;
        logic acc;
        #3;
        check("rst_ov", out_valid, 0);
        check("rst_ir", in_ready, 1);
        check("rst_diff", diff, 0);
        check("rst_flags", {borrow, ovf}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        run_one(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
        run_one(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
        run_one(16'h1000, 16'h0FFF, 16'h0001, 1'b0, 1'b0);
        run_one(16'h8000, 16'h0001, SAT_D, 1'b0, 1'b1);
        run_one(16'h7FFF, 16'hFFFF, SAT_D == 16'h8000 ? 16'h7FFF : 16'h8000, 1'b1, 1'b1);

        // Fill under backpressure, then drain at full rate.
        for (int i = 0; i < 10; i++) begin
            ta[i] = 16'($urandom);
            tb[i] = 16'($urandom);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = ta[idx]; b = tb[idx];
            @(negedge clk);
            if (in_ready) idx++;
        end
        check("full_accepts", idx, 4);
        check("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("drain_valid", out_valid, 1);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            in_valid = idx < 10;
            if (idx < 10) begin a = ta[idx]; b = tb[idx]; end
        end
        in_valid = 1'b0;
        check("drain_count", idx, 10);
        cnt = 0;
        while (q.size() > 0 && cnt < 50) begin @(negedge clk); cnt++; end
        check("drain_empty", q.size(), 0);

        // Random traffic with random backpressure.
        sent = 0; cyc = 0; acc = 1'b1;
        while (sent < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            if (!in_valid || acc) begin
                in_valid = ($urandom % 4) != 0;
                a = ($urandom % 8 == 0) ? 16'h8000 : 16'($urandom);
                b = ($urandom % 8 == 0) ? 16'h7FFF : 16'($urandom);
            end
            out_ready = ($urandom % 3) != 0;
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sent++;
            cyc++;
        end
        check("rand_sent", sent, 1000);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        cnt = 0;
        while (q.size() > 0 && cnt < 50) begin @(negedge clk); cnt++; end
        check("rand_empty", q.size(), 0);

        // Asynchronous reset with items in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #2;
        check("pre_rst_ov", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("arst_ov", out_valid, 0);
        check("arst_ir", in_ready, 1);
        check("arst_diff", diff, 0);
        q.delete();
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            cnt += int'(out_valid);
        end
        check("stale_items", cnt, 0);
        run_one(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
